// File: rtl/i2c_core_pkg.sv
// Shared types for the I2C bit engine.
// bit_op_t : 3-bit bus operation code; TX_0, TX_1, RX, RX_ACK and RS are
//            defined here, and codes 5..7 behave as TX_1.
// state_t  : bit-engine sequencer states.
// phase_t  : quarter-SCL-period index, ph0..ph3.
package i2c_core_pkg;

    typedef logic [2:0] bit_op_t;

    localparam bit_op_t TX_0   = 3'd0;
    localparam bit_op_t TX_1   = 3'd1;
    localparam bit_op_t RX     = 3'd2;
    localparam bit_op_t RX_ACK = 3'd3;
    localparam bit_op_t RS     = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        STOP,
        DONE
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH0 = 2'd0;
    localparam phase_t PH1 = 2'd1;
    localparam phase_t PH2 = 2'd2;
    localparam phase_t PH3 = 2'd3;

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-SCL-period prescaler.
// clk        : system clock
// srst       : synchronous active-high reset
// start      : restart the count at the beginning of ph0
// phase_tick : high in the last clk cycle of each phase
// phase      : current quarter phase, advances ph0..ph3 and wraps
module i2c_phase_timer
    import i2c_core_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic   clk,
    input  logic   srst,
    input  logic   start,
    output logic   phase_tick,
    output phase_t phase
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign phase_tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (srst || start) begin
            cnt   <= '0;
            phase <= PH0;
        end else if (phase_tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// I2C bit-level sequencer: executes a latched list of bus ops framed by
// START and STOP, each step lasting four phases of CLK_DIV clocks.
// clk_i     : system clock
// srst_i    : synchronous active-high reset (bus released, no STOP)
// ops_i     : packed bit_op_t list, element 0 in bits [2:0] runs first
// op_cnt_i  : number of valid ops, clamped to MAX_OPS
// valid_i   : request; accepted when ready_o is high
// ready_o   : high only while idle
// rx_data_o : MSB-first shift of bits received by RX ops
// done_o    : one-cycle completion pulse
// ack_err_o : a NACK was sampled during an RX_ACK op
// scl_o     : SCL open-drain enable (0 pulls low, 1 releases)
// sda_o     : SDA open-drain enable (0 pulls low, 1 releases)
// sda_i     : synchronised bus SDA level
module i2c_bit_engine
    import i2c_core_pkg::*;
#(
    parameter int unsigned MAX_OPS = 55,
    parameter int unsigned CLK_DIV = 125,
    parameter int unsigned RX_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic [MAX_OPS*3-1:0]         ops_i,
    input  logic [$clog2(MAX_OPS+1)-1:0] op_cnt_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [RX_W-1:0]              rx_data_o,
    output logic                         done_o,
    output logic                         ack_err_o,
    output logic                         scl_o,
    output logic                         sda_o,
    input  logic                         sda_i
);

    localparam int unsigned CW = $clog2(MAX_OPS + 1);

    state_t               state_q, state_d;
    logic [MAX_OPS*3-1:0] ops_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        idx_q;
    logic [CW-1:0]        cnt_clamped;
    logic [RX_W-1:0]      rx_q;
    logic                 ack_err_q;

    logic                 phase_tick;
    phase_t               phase;
    logic                 handshake;
    logic                 seg_end;
    logic                 sample;
    logic                 last_op;
    bit_op_t              cur_op;

    i2c_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk       (clk_i),
        .srst      (srst_i),
        .start     (handshake),
        .phase_tick(phase_tick),
        .phase     (phase)
    );

    // Gated by reset so no request is accepted in the reset cycle itself.
    assign ready_o     = (state_q == IDLE) && !srst_i;
    assign handshake   = valid_i && ready_o;
    assign seg_end     = phase_tick && (phase == PH3);
    assign sample      = phase_tick && (phase == PH2) && (state_q == BIT);
    assign cur_op      = ops_q[3*idx_q +: 3];
    assign last_op     = (idx_q == cnt_q - 1'b1);
    assign cnt_clamped = (op_cnt_i > CW'(MAX_OPS)) ? CW'(MAX_OPS) : op_cnt_i;

    assign done_o      = (state_q == DONE);
    assign rx_data_o   = rx_q;
    assign ack_err_o   = ack_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (handshake) state_d = START;
            START: if (seg_end) state_d = (cnt_q == '0) ? STOP : BIT;
            // A NACK sampled in ph2 aborts once the current bit finishes.
            BIT:   if (seg_end && (last_op || ack_err_q)) state_d = STOP;
            STOP:  if (seg_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            START: begin
                scl_o = (phase != PH3);
                sda_o = (phase == PH0);
            end
            BIT: begin
                scl_o = (phase == PH1) || (phase == PH2);
                case (cur_op)
                    TX_0:       sda_o = 1'b0;
                    RX, RX_ACK: sda_o = 1'b1;
                    RS:         sda_o = (phase == PH0) || (phase == PH1);
                    default:    sda_o = 1'b1;
                endcase
            end
            STOP: begin
                scl_o = (phase != PH0);
                sda_o = (phase == PH2) || (phase == PH3);
            end
            default: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rx_q      <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                ops_q     <= ops_i;
                cnt_q     <= cnt_clamped;
                idx_q     <= '0;
                rx_q      <= '0;
                ack_err_q <= 1'b0;
            end
            if (sample) begin
                if (cur_op == RX) begin
                    rx_q <= {rx_q[RX_W-2:0], sda_i};
                end
                if (cur_op == RX_ACK && sda_i) begin
                    ack_err_q <= 1'b1;
                end
            end
            if (state_q == BIT && seg_end && !(last_op || ack_err_q)) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule
